serial_subtractor: RTL

Bit-serial WIDTH-bit subtractor computing d = x − y − bin, one bit per clock, LSB first, through a single full-subtractor cell. It is the subtraction counterpart of the team's ripple-carry adder. It trades area for latency and exposes a start/busy/done handshake so a sequencer can drive it. Operands are captured on start; the result is presented in registered form on completion.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor_full_sub.sv | 13 +
 rtl/serial_subtractor.sv | 99 +++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;

    modport master (
        output start, x, y, bin,
        input  busy, done, d, bout
    );

    modport slave (
        input  start, x, y, bin,
        output busy, done, d, bout
    );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full_sub cell shared over all bits.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_q, b_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             di;
    logic             bnext;

    full_sub u_full_sub (
        .a  (xs_q[0]),
        .b  (ys_q[0]),
        .bi (b_q),
        .d  (di),
        .bo (bnext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            rs_q    <= '0;
            d_q     <= '0;
            b_q     <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
            b_q     <= b_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        rs_d    = rs_q;
        d_d     = d_q;
        b_d     = b_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    xs_d    = bus.x;
                    ys_d    = bus.y;
                    b_d     = bus.bin;
                    cnt_d   = '0;
                    rs_d    = '0;
                end
            end
            RUN: begin
                xs_d  = {1'b0, xs_q[WIDTH-1:1]};
                ys_d  = {1'b0, ys_q[WIDTH-1:1]};
                rs_d  = {di, rs_q[WIDTH-1:1]};
                b_d   = bnext;
                cnt_d = cnt_q + CW'(1);
                // Final bit publishes straight from the cell so d/bout update on this same edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = {di, rs_q[WIDTH-1:1]};
                    bout_d  = bnext;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;

endmodule
